// File: rtl/slave_spi.sv
// slave_spi: byte-oriented SPI responder (SCLK idles high, sample on fall,
// drive on rise, MSB first). Pins are oversampled with the system clock.
module slave_spi #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun
);

  // Synchronizer chains: [0],[1] synchronize, [2] is the edge-detect history.
  logic [2:0] ss_q, sclk_q;
  logic [1:0] mosi_q;

  logic       active_q, active_d;
  logic [2:0] bc_q, bc_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  logic       miso_q, miso_d;
  logic       oe_q, oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       underrun_q, underrun_d;

  logic       ss_fall, ss_rise, sclk_fall, sclk_rise;
  logic       load;
  logic [7:0] load_byte;

  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];

  // Holding register drains into the shifter; empty means the idle pattern.
  assign load_byte = full_q ? hold_q : IDLE_BYTE;

  // Pin synchronizers, reset to the idle-high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b111;
      mosi_q <= 2'b11;
    end else begin
      ss_q   <= {ss_q[1:0], ss};
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  // Next-state logic; an SS edge wins over a coincident SCLK edge.
  always_comb begin
    active_d   = active_q;
    bc_d       = bc_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    hold_d     = hold_q;
    full_d     = full_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;

    if (ss_fall) begin
      active_d = 1'b1;
      bc_d     = 3'd0;
      oe_d     = 1'b1;
      load     = 1'b1;
    end else if (ss_rise) begin
      active_d = 1'b0;
      bc_d     = 3'd0;
      oe_d     = 1'b0;
      miso_d   = 1'b1;
    end else if (active_q && sclk_fall) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_q[1]};
      bc_d       = bc_q + 3'd1;
      if (bc_q == 3'd7) begin
        rx_data_d  = {rx_shift_q[6:0], mosi_q[1]};
        rx_valid_d = 1'b1;
      end
    end else if (active_q && sclk_rise) begin
      if (bc_q == 3'd0) begin
        load = 1'b1;
      end else begin
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
        miso_d     = tx_shift_q[6];
      end
    end

    if (load) begin
      tx_shift_d = load_byte;
      miso_d     = load_byte[7];
      if (full_q) full_d = 1'b0;
      else        underrun_d = 1'b1;
    end

    // Accept only when empty at the start of the cycle; a same-cycle load
    // from empty still sends the idle byte and keeps the new one.
    if (tx_valid && !full_q) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      bc_q       <= 3'd0;
      rx_shift_q <= 8'h00;
      tx_shift_q <= 8'h00;
      hold_q     <= 8'h00;
      full_q     <= 1'b0;
      miso_q     <= 1'b1;
      oe_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      active_q   <= active_d;
      bc_q       <= bc_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~full_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_slave_spi.sv
// tb_slave_spi: directed vectors for slave_spi with hand-computed results.
module tb_slave_spi;

  logic       clk = 1'b0;
  logic       rst_n, ss, sclk, mosi;
  logic       miso, miso_oe, rx_valid, tx_valid, tx_ready, tx_underrun;
  logic [7:0] rx_data, tx_data;

  int vectors = 0;
  int miscompares = 0;
  int rx_cnt = 0;
  int un_cnt = 0;
  logic [7:0] rx_log [16];
  logic [7:0] got0, got1, got2;
  int rx_base;

  slave_spi #(.IDLE_BYTE(8'hFF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ss          (ss),
    .sclk        (sclk),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  // Log strobes on the falling clock edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt & 15] = rx_data;
      rx_cnt++;
    end
    if (tx_underrun) un_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one byte, waiting a bounded time for the holding register.
  task automatic push(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!tx_ready) begin
      check("push_wait", 32'(tx_ready), 32'd1);
    end else begin
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
    end
  endtask

  task automatic ss_begin();
    ss = 1'b0;
    #80;
  endtask

  task automatic ss_end();
    #80;
    ss = 1'b1;
    #80;
  endtask

  // Master clocks n bits, sampling MISO just before each falling edge.
  task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = d[7-i];
      #40;
      got  = {got[6:0], miso};
      sclk = 1'b0;
      #80;
      sclk = 1'b1;
      #40;
    end
  endtask

  initial begin
    rst_n = 1'b0; ss = 1'b1; sclk = 1'b1; mosi = 1'b1;
    tx_valid = 1'b0; tx_data = 8'h00;
    #25 rst_n = 1'b1;
    #20;

    // Reset values
    check("rst_miso", 32'(miso), 32'd1);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_underrun", 32'(tx_underrun), 32'd0);

    // Single byte: MOSI A5, preloaded 3C
    push(8'h3C);
    check("t1_ready_low", 32'(tx_ready), 32'd0);
    rx_base = rx_cnt;
    ss_begin();
    check("t1_oe", 32'(miso_oe), 32'd1);
    check("t1_miso_msb", 32'(miso), 32'd0);
    check("t1_ready_back", 32'(tx_ready), 32'd1);
    spi_bits(8'hA5, 8, got0);
    check("t1_miso_byte", 32'(got0), 32'h3C);
    check("t1_rx_cnt", 32'(rx_cnt - rx_base), 32'd1);
    check("t1_rx_data", 32'(rx_log[rx_base & 15]), 32'hA5);
    ss_end();
    check("t1_end_oe", 32'(miso_oe), 32'd0);
    check("t1_end_miso", 32'(miso), 32'd1);

    // Three-byte burst, refilled after each load
    push(8'h11);
    rx_base = rx_cnt;
    ss_begin();
    push(8'h22);
    spi_bits(8'h01, 8, got0);
    push(8'h33);
    spi_bits(8'h80, 8, got1);
    spi_bits(8'hFF, 8, got2);
    ss_end();
    check("t2_miso0", 32'(got0), 32'h11);
    check("t2_miso1", 32'(got1), 32'h22);
    check("t2_miso2", 32'(got2), 32'h33);
    check("t2_rx_cnt", 32'(rx_cnt - rx_base), 32'd3);
    check("t2_rx0", 32'(rx_log[rx_base & 15]), 32'h01);
    check("t2_rx1", 32'(rx_log[(rx_base + 1) & 15]), 32'h80);
    check("t2_rx2", 32'(rx_log[(rx_base + 2) & 15]), 32'hFF);

    // Empty holding register at SS fall
    un_cnt  = 0;
    rx_base = rx_cnt;
    ss_begin();
    check("t3_underrun", 32'(un_cnt), 32'd1);
    check("t3_miso_msb", 32'(miso), 32'd1);
    spi_bits(8'h5A, 8, got0);
    check("t3_miso_byte", 32'(got0), 32'hFF);
    check("t3_rx_cnt", 32'(rx_cnt - rx_base), 32'd1);
    check("t3_rx_data", 32'(rx_log[rx_base & 15]), 32'h5A);
    ss_end();

    // Partial byte then a full one
    rx_base = rx_cnt;
    ss_begin();
    spi_bits(8'hF0, 5, got0);
    ss_end();
    check("t4_no_rx", 32'(rx_cnt - rx_base), 32'd0);
    check("t4_oe", 32'(miso_oe), 32'd0);
    check("t4_miso", 32'(miso), 32'd1);
    push(8'h96);
    ss_begin();
    spi_bits(8'hC3, 8, got0);
    ss_end();
    check("t4_miso_byte", 32'(got0), 32'h96);
    check("t4_rx_cnt", 32'(rx_cnt - rx_base), 32'd1);
    check("t4_rx_data", 32'(rx_log[rx_base & 15]), 32'hC3);

    // Reset mid-transfer
    push(8'h77);
    ss_begin();
    push(8'h44);
    spi_bits(8'h0F, 3, got0);
    rst_n = 1'b0;
    #1;
    check("t5_miso", 32'(miso), 32'd1);
    check("t5_oe", 32'(miso_oe), 32'd0);
    check("t5_rx_data", 32'(rx_data), 32'h00);
    check("t5_ready", 32'(tx_ready), 32'd1);
    check("t5_underrun", 32'(tx_underrun), 32'd0);
    ss = 1'b1; sclk = 1'b1;
    #30 rst_n = 1'b1;
    #40;
    push(8'hE7);
    rx_base = rx_cnt;
    ss_begin();
    spi_bits(8'h3C, 8, got0);
    ss_end();
    check("t5_miso_byte", 32'(got0), 32'hE7);
    check("t5_rx_cnt", 32'(rx_cnt - rx_base), 32'd1);
    check("t5_rx_data", 32'(rx_log[rx_base & 15]), 32'h3C);

    // SCLK with SS high is ignored; held TX_VALID waits for the load
    rx_base = rx_cnt;
    for (int i = 0; i < 10; i++) begin
      mosi = i[0];
      sclk = 1'b0; #80;
      sclk = 1'b1; #80;
    end
    check("t6_no_rx", 32'(rx_cnt - rx_base), 32'd0);
    check("t6_no_oe", 32'(miso_oe), 32'd0);
    push(8'h12);
    tx_data  = 8'h34;
    tx_valid = 1'b1;
    #50;
    check("t6_ready_held", 32'(tx_ready), 32'd0);
    ss_begin();
    check("t6_second_taken", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    spi_bits(8'h00, 8, got0);
    spi_bits(8'h00, 8, got1);
    ss_end();
    check("t6_miso0", 32'(got0), 32'h12);
    check("t6_miso1", 32'(got1), 32'h34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slave_spi.md
# slave_spi

Byte-oriented SPI responder for the device end of the link driven by our SPI bus master. It oversamples SS, SCLK and MOSI with the local system clock and shifts MOSI into a receive register, delivering each completed byte as a one-cycle strobe. It shifts the byte in a one-entry transmit holding register out on MISO, and substitutes 0xFF when no byte is ready. It sits between the external SPI pins and local register/FIFO logic.

## Interface
Parameters:
- IDLE_BYTE, 8'hFF, byte shifted out on MISO when the transmit holding register is empty at a byte load.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  reset; one clock, asynchronous, active-low.
- SS  input  1  SPI select from the master, active-low, asynchronous to CLK.
- SCLK  input  1  SPI clock, idles high, asynchronous to CLK.
- MOSI  input  1  serial data from the master, MSB first.
- MISO  output  1  serial data to the master, MSB first, registered.
- MISO_OE  output  1  MISO output enable, high while SS is low after synchronization.
- RX_DATA  output  8  last complete received byte, held until the next byte completes.
- RX_VALID  output  1  one-CLK strobe; RX_DATA has been updated.
- TX_DATA  input  8  byte offered for transmission.
- TX_VALID  input  1  TX_DATA is offered.
- TX_READY  output  1  holding register empty; a transfer is accepted when TX_VALID & TX_READY.
- TX_UNDERRUN  output  1  one-CLK strobe; IDLE_BYTE was loaded because the holding register was empty.

## Operation
- SS, SCLK and MOSI each pass through a 2-flop synchronizer. A third flop on SS and SCLK provides edge detection. All actions below fire on the detected edge.
- SPI mode: SCLK idles high. MOSI is sampled on the SCLK falling edge. MISO changes on the SCLK rising edge. Bit 7 is the first bit on both lines.
- State:
  - 3-bit bit counter BC.
  - 8-bit RX shifter.
  - 8-bit TX shifter.
  - Holding register with a full flag; TX_READY = !full.
  - Phase: IDLE (SS synced high) and ACTIVE (SS synced low).
- IDLE -> ACTIVE on the SS falling edge:
  - BC = 0.
  - Load the TX shifter from the holding register (clear full) or from IDLE_BYTE (pulse TX_UNDERRUN).
  - MISO = bit 7 of the loaded value; MISO_OE = 1.
- ACTIVE, SCLK falling:
  - RX shifter = {RX shifter[6:0], MOSI_sync}; BC = BC + 1, wrapping 7 -> 0.
  - On wrap, RX_DATA = the new shifter value and RX_VALID pulses.
- ACTIVE, SCLK rising:
  - If BC == 0 (byte boundary): load the TX shifter as on SS fall and drive its bit 7.
  - Otherwise shift the TX shifter left and drive the new bit 7.
- ACTIVE -> IDLE on the SS rising edge:
  - MISO_OE = 0, MISO = 1, BC = 0.
  - A partial received byte is discarded with no RX_VALID.
  - An unsent TX shifter content is dropped. The holding register is untouched.
- SCLK edges while SS is synced high are ignored.
- Holding register accepts a byte whenever TX_READY is high, in either phase.
  - Accept and load in the same cycle: TX_READY was already 0, so no accept happens. An empty register loads IDLE_BYTE, and a byte accepted in that cycle is kept for the next load.
- SS edge and SCLK edge detected in the same cycle: the SS edge has priority and the SCLK edge is dropped.

## Timing
- Reset values: MISO = 1, MISO_OE = 0, RX_DATA = 8'h00, RX_VALID = 0, TX_READY = 1, TX_UNDERRUN = 0, BC = 0, holding register empty, synchronizer flops = 1.
- Reset asserted mid-transfer returns everything to reset values immediately. The byte in progress is lost.
- Pin-to-action latency is 3 CLK rising edges: 2 synchronizer edges plus 1 edge for the registered action. This applies to MISO update, MISO_OE change and RX_VALID/RX_DATA.
- Master requirements:
  - SCLK high and low phases are each at least 4 CLK periods.
  - SS falls at least 4 CLK periods before the first SCLK falling edge.
  - SS rises at least 4 CLK periods after the last SCLK edge.
- RX_VALID and TX_UNDERRUN are high for exactly one CLK. There is no RX backpressure; RX_DATA is overwritten by the next byte.
- TX_READY falls in the CLK after an accept and rises in the CLK after a load from a full holding register.

## Test plan
- Reset, then SS low, one byte with MOSI = 0xA5 and TX_DATA = 0x3C preloaded -> MISO shows 0x3C MSB first; RX_VALID pulses once with RX_DATA = 0xA5; TX_READY returns to 1.
- Three-byte burst, MOSI 0x01,0x80,0xFF, holding refilled after each TX_READY -> three RX_VALID pulses with matching data; MISO carries the three queued bytes back-to-back with no gap bit.
- Holding register empty at SS fall -> TX_UNDERRUN pulses once; MISO shifts 0xFF; received byte still delivered.
- SS raised after 5 SCLK falling edges -> no RX_VALID, MISO_OE = 0, MISO = 1; next transfer receives a full correct byte.
- RST_N pulsed low after 3 bits -> all outputs at reset values within the same cycle; following transfer correct.
- SCLK toggling with SS high, then TX_VALID held while TX_READY = 0 -> no RX_VALID, no MISO_OE; the second TX_DATA is accepted only after the load.
